// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Fetches one 32-bit instruction at a time from instruction memory, latches
// it for decode, and holds it until the downstream stages report completion.
// It then moves to the next sequential address or to a redirect target.
//
// Build option:
//   IF_MISALIGN_TRAP_EN  When defined, a redirect to a target with
//                        addr[1:0] != 0 parks the stage in S_ERR with
//                        fetch_err=1 until rst. When undefined, the redirect
//                        target is word-aligned by clearing addr[1:0],
//                        S_ERR is never entered, and fetch_err is constant 0.
//
// Ports:
//   clk                input   clock; all state changes on its rising edge
//   rst                input   synchronous active-high reset
//   imem_req           output  fetch request (high in S_FETCH)
//   imem_addr [63:0]   output  fetch address (== pc_cur)
//   imem_ack           input   memory accepts and returns data in-cycle
//   imem_rdata [31:0]  input   fetched instruction
//   inst_done          input   downstream finished the current instruction
//   pc_jmp             input   redirect request, qualified by inst_done
//   pc_jmpaddr [63:0]  input   redirect target
//   inst [31:0]        output  latched instruction
//   pc [63:0]          output  address of the latched instruction
//   pc_cur [63:0]      output  address being / next to be fetched
//   inst_valid         output  inst/pc hold a valid instruction
//   instcycle_cnt_val  output  per-instruction phase counter (saturates 255)
//   fetch_err          output  misaligned-redirect error flag
//   state_dbg [1:0]    output  current FSM state (0 fetch, 1 exec, 2 err)
//
// Handshake: imem_req/imem_addr are driven from registered state only, so
// they stay stable every cycle the stage waits in S_FETCH. A transfer happens
// on any rising edge where imem_req=1 and imem_ack=1; imem_rdata is sampled
// at that edge. inst_done (with pc_jmp/pc_jmpaddr) is a one-cycle completion
// strobe that is only honoured in S_EXEC.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        inst_done,
  input  logic        pc_jmp,
  input  logic [63:0] pc_jmpaddr,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic [63:0] pc_cur,
  output logic        inst_valid,
  output logic [7:0]  instcycle_cnt_val,
  output logic        fetch_err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_cur_q, pc_cur_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_cur_q <= RESET_PC;
      pc_q     <= 64'd0;
      inst_q   <= 32'd0;
      valid_q  <= 1'b0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_cur_q <= pc_cur_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_cur_d = pc_cur_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          pc_d    = pc_cur_q;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (inst_done) begin
          valid_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_FETCH;
          if (pc_jmp) begin
`ifdef IF_MISALIGN_TRAP_EN
            pc_cur_d = pc_jmpaddr;
            if (pc_jmpaddr[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
`else
            pc_cur_d = {pc_jmpaddr[63:2], 2'b00};
`endif
          end else begin
            // Sequential successor; wraps naturally at 2^64.
            pc_cur_d = pc_q + 64'd4;
          end
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_ERR: begin
        // Terminal until rst.
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imem_req          = (state_q == S_FETCH);
  assign imem_addr         = pc_cur_q;
  assign inst              = inst_q;
  assign pc                = pc_q;
  assign pc_cur            = pc_cur_q;
  assign inst_valid        = valid_q;
  assign instcycle_cnt_val = cnt_q;
  assign state_dbg         = state_q;

`ifdef IF_MISALIGN_TRAP_EN
  assign fetch_err = err_q;
`else
  // Without the trap the error register never changes; keep it out of the
  // output and mark the otherwise-unread signals.
  logic unused_err;
  assign unused_err = err_q ^ (^pc_jmpaddr[1:0]);
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// Inputs are driven and outputs sampled at the falling edge; the DUT
// updates on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_done;
  logic        pc_jmp;
  logic [63:0] pc_jmpaddr;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] pc_cur;
  logic        inst_valid;
  logic [7:0]  instcycle_cnt_val;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .inst_done         (inst_done),
    .pc_jmp            (pc_jmp),
    .pc_jmpaddr        (pc_jmpaddr),
    .inst              (inst),
    .pc                (pc),
    .pc_cur            (pc_cur),
    .inst_valid        (inst_valid),
    .instcycle_cnt_val (instcycle_cnt_val),
    .fetch_err         (fetch_err),
    .state_dbg         (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    inst_done  = 1'b0;
    pc_jmp     = 1'b0;
    pc_jmpaddr = 64'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-cycle fetch: ack in the current (fetch) cycle.
  task automatic fetch_now(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // Complete the current instruction.
  task automatic finish_inst(input logic jmp, input logic [63:0] tgt);
    inst_done  = 1'b1;
    pc_jmp     = jmp;
    pc_jmpaddr = tgt;
    tick();
    inst_done  = 1'b0;
    pc_jmp     = 1'b0;
    pc_jmpaddr = 64'd0;
  endtask

  logic [7:0] exp_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();

    // Reset state
    chk("rst_pc_cur", pc_cur, RESET_PC);
    chk("rst_pc", pc, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_cnt", {56'd0, instcycle_cnt_val}, 64'd0);
    chk("rst_err", {63'd0, fetch_err}, 64'd0);

    // First cycle after reset: request up, ack immediately
    rst = 1'b0;
    chk("post_rst_req", {63'd0, imem_req}, 64'd1);
    chk("first_addr", imem_addr, 64'h8000_0000);
    fetch_now(32'h0000_0513);
    chk("first_inst", {32'd0, inst}, 64'h0000_0513);
    chk("first_pc", pc, 64'h8000_0000);
    chk("first_valid", {63'd0, inst_valid}, 64'd1);
    chk("first_cnt", {56'd0, instcycle_cnt_val}, 64'd1);
    chk("exec_req_low", {63'd0, imem_req}, 64'd0);

    // Ack in exec must be ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    chk("exec_ack_ignored", {32'd0, inst}, 64'h0000_0513);
    chk("exec_cnt2", {56'd0, instcycle_cnt_val}, 64'd2);

    // Sequential completion
    finish_inst(1'b0, 64'd0);
    chk("seq_addr", imem_addr, 64'h8000_0004);
    chk("seq_valid", {63'd0, inst_valid}, 64'd0);
    chk("seq_cnt", {56'd0, instcycle_cnt_val}, 64'd0);
    chk("seq_req", {63'd0, imem_req}, 64'd1);

    // Delayed ack: request and address stable across 3 wait cycles,
    // inst_done ignored while fetching
    do_reset();
    for (int i = 0; i < 3; i++) begin
      inst_done = 1'b1;
      chk("wait_req", {63'd0, imem_req}, 64'd1);
      chk("wait_addr", imem_addr, 64'h8000_0000);
      chk("wait_cnt", {56'd0, instcycle_cnt_val}, 64'd0);
      tick();
      inst_done = 1'b0;
    end
    chk("wait_req4", {63'd0, imem_req}, 64'd1);
    chk("wait_addr4", imem_addr, 64'h8000_0000);
    chk("wait_valid4", {63'd0, inst_valid}, 64'd0);
    fetch_now(32'h0010_0093);
    chk("late_inst", {32'd0, inst}, 64'h0010_0093);
    chk("late_cnt", {56'd0, instcycle_cnt_val}, 64'd1);

    // Long exec: counter saturates at 255
    exp_cnt = 8'd1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk("sat_cnt", {56'd0, instcycle_cnt_val}, {56'd0, exp_cnt});
    end
    chk("sat_final", {56'd0, instcycle_cnt_val}, 64'd255);
    finish_inst(1'b0, 64'd0);
    chk("sat_next_addr", imem_addr, 64'h8000_0004);

    // Aligned redirect
    fetch_now(32'h0000_0013);
    chk("jmp_src_pc", pc, 64'h8000_0004);
    finish_inst(1'b1, 64'h8000_0100);
    chk("jmp_addr", imem_addr, 64'h8000_0100);
    chk("jmp_valid", {63'd0, inst_valid}, 64'd0);
    chk("jmp_req", {63'd0, imem_req}, 64'd1);

    // Misaligned redirect
    fetch_now(32'h0000_0013);
    finish_inst(1'b1, 64'h8000_0102);
`ifdef IF_MISALIGN_TRAP_EN
    chk("mis_err", {63'd0, fetch_err}, 64'd1);
    chk("mis_req", {63'd0, imem_req}, 64'd0);
    chk("mis_pc_cur", pc_cur, 64'h8000_0102);
    // S_ERR ignores ack and inst_done
    imem_ack  = 1'b1;
    inst_done = 1'b1;
    tick();
    tick();
    idle_inputs();
    chk("err_sticky", {63'd0, fetch_err}, 64'd1);
    chk("err_req_low", {63'd0, imem_req}, 64'd0);
    chk("err_valid", {63'd0, inst_valid}, 64'd0);
`else
    chk("mis_align_addr", imem_addr, 64'h8000_0100);
    chk("mis_err0", {63'd0, fetch_err}, 64'd0);
    chk("mis_req", {63'd0, imem_req}, 64'd1);
`endif

    // Wrap at top of address space, then reset over an in-flight fetch
    do_reset();
    chk("rst_clears_err", {63'd0, fetch_err}, 64'd0);
    fetch_now(32'h0000_0001);
    finish_inst(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_now(32'h1234_5678);
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    finish_inst(1'b0, 64'd0);
    chk("wrap_pc_cur", pc_cur, 64'd0);
    chk("hold_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("hold_inst", {32'd0, inst}, 64'h1234_5678);

    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    idle_inputs();
    chk("rst_ack_inst", {32'd0, inst}, 64'd0);
    chk("rst_ack_pc", pc, 64'd0);
    chk("rst_ack_pc_cur", pc_cur, RESET_PC);
    chk("rst_ack_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_ack_req", {63'd0, imem_req}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port imem_req  output  1  instruction-memory fetch request.
REQ-005 SHALL provide port imem_addr  output  64  fetch address; valid while imem_req=1.
REQ-006 SHALL provide port imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-007 SHALL provide port imem_rdata  input  32  fetched instruction; sampled only when imem_req=1 and imem_ack=1.
REQ-008 SHALL provide port inst_done  input  1  downstream stages finished the current instruction.
REQ-009 SHALL provide port pc_jmp  input  1  redirect request, qualified by inst_done.
REQ-010 SHALL provide port pc_jmpaddr  input  64  redirect target.
REQ-011 SHALL provide port inst  output  32  latched instruction for decode.
REQ-012 SHALL provide port pc  output  64  address of the latched instruction.
REQ-013 SHALL provide port pc_cur  output  64  address currently being or next to be fetched.
REQ-014 SHALL provide port inst_valid  output  1  inst/pc hold a valid instruction.
REQ-015 SHALL provide port instcycle_cnt_val  output  8  instruction phase counter for downstream stages.
REQ-016 SHALL provide port fetch_err  output  1  misaligned-redirect error flag (see Configuration).

Function
REQ-017 SHALL implement FSM states S_FETCH, S_EXEC, S_ERR.
REQ-018 In S_FETCH it SHALL drive imem_req=1 and imem_addr=pc_cur, holding both stable until imem_ack.
REQ-019 On imem_ack in S_FETCH it SHALL, next edge: inst<=imem_rdata, pc<=pc_cur, inst_valid<=1, instcycle_cnt_val<=1, state<=S_EXEC.
REQ-020 In S_EXEC it SHALL drive imem_req=0 and increment instcycle_cnt_val by 1 per cycle, saturating at 255.
REQ-021 On inst_done in S_EXEC with pc_jmp=0 it SHALL set pc_cur<=pc+4 (mod 2^64), inst_valid<=0, instcycle_cnt_val<=0, state<=S_FETCH.
REQ-022 On inst_done in S_EXEC with pc_jmp=1 it SHALL set pc_cur<=pc_jmpaddr (per Configuration), with the other updates as REQ-021.
REQ-023 inst_done and pc_jmp SHALL be ignored in S_FETCH and S_ERR; imem_ack SHALL be ignored outside S_FETCH.
REQ-024 inst and pc SHALL hold their values from instruction latch until the next imem_ack.
REQ-025 Minimum per-instruction latency SHALL be 2 cycles (ack in cycle 0 of fetch, inst_done in first S_EXEC cycle).
REQ-026 S_ERR SHALL drive imem_req=0 and fetch_err=1, and be left only by rst.

Reset
REQ-027 On rst=1 at an edge: state<=S_FETCH, pc_cur<=RESET_PC, pc<=0, inst<=0, inst_valid<=0, instcycle_cnt_val<=0, fetch_err<=0.
REQ-028 rst SHALL take priority over imem_ack, inst_done and pc_jmp in the same cycle; a fetch in flight is abandoned.
REQ-029 imem_req SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro IF_MISALIGN_TRAP_EN: when defined, a redirect with pc_jmpaddr[1:0]!=0 SHALL enter S_ERR with pc_cur<=pc_jmpaddr and fetch_err<=1.
REQ-031 When IF_MISALIGN_TRAP_EN is undefined, redirect SHALL load pc_cur<={pc_jmpaddr[63:2],2'b00}, S_ERR SHALL be unreachable, and fetch_err SHALL be tied 0.

Verification
REQ-032 Reset then ack=1 on first cycle, rdata=32'h00000513 -> imem_addr=64'h80000000; next cycle inst=32'h00000513, pc=64'h80000000, inst_valid=1, cnt=1.
REQ-033 Ack delayed 3 cycles -> imem_req and imem_addr=64'h80000000 stable all 4 cycles; cnt stays 0 until ack.
REQ-034 Hold inst_done=0 for 300 cycles in S_EXEC -> cnt reaches 255 and stays; inst_done with pc_jmp=0 -> next imem_addr=64'h80000004.
REQ-035 inst_done=1, pc_jmp=1, pc_jmpaddr=64'h80000100 -> next imem_addr=64'h80000100, inst_valid=0; with target 64'h80000102: macro defined -> fetch_err=1, imem_req=0; undefined -> imem_addr=64'h80000100.
REQ-036 rst=1 coincident with imem_ack, pc=64'hFFFFFFFF_FFFFFFFC previously -> inst unchanged to 0, pc_cur=RESET_PC; separately pc=64'hFFFFFFFF_FFFFFFFC + inst_done -> pc_cur=0 (wrap).
